// File: rtl/uart_seq_checker_if.sv
// Monitor-side bundle for uart_seq_checker: serial line and arm input in, verdict outputs back.
// The timeout output exists only when SEQ_CHECK_TIMEOUT_EN is defined.
interface uart_seq_checker_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
);
    logic                 rx_line;
    logic                 enable;
    logic [WIDTH-1:0]     rx_data;
    logic                 rx_valid;
    logic [WIDTH-1:0]     expected;
    logic                 done;
    logic                 pass;
    logic                 fail;
    logic                 frame_err;
    logic [CNT_WIDTH-1:0] err_cnt;
    logic [CNT_WIDTH-1:0] frame_cnt;
    logic [WIDTH-1:0]     bad_data;
`ifdef SEQ_CHECK_TIMEOUT_EN
    logic                 timeout;
`endif

    modport master (
`ifdef SEQ_CHECK_TIMEOUT_EN
        input  timeout,
`endif
        output rx_line, enable,
        input  rx_data, rx_valid, expected, done, pass, fail, frame_err,
               err_cnt, frame_cnt, bad_data
    );

    modport slave (
`ifdef SEQ_CHECK_TIMEOUT_EN
        output timeout,
`endif
        input  rx_line, enable,
        output rx_data, rx_valid, expected, done, pass, fail, frame_err,
               err_cnt, frame_cnt, bad_data
    );
endinterface

// File: rtl/uart_seq_checker.sv
// UART TX-line monitor: deframes words and checks them against START_VALUE + k*STEP up to END_VALUE.
// Optional idle watchdog (parameter TIMEOUT_CLKS, output timeout) enabled by SEQ_CHECK_TIMEOUT_EN.
module uart_seq_checker #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 2,
    parameter int START_VALUE  = 1,
    parameter int STEP         = 1,
    parameter int END_VALUE    = (1 << WIDTH) - 1,
    parameter int STOP_ON_ERR  = 1,
    parameter int CNT_WIDTH    = 8
`ifdef SEQ_CHECK_TIMEOUT_EN
    , parameter int TIMEOUT_CLKS = 4096
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_seq_checker_if.slave mon
);
    localparam int CC_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(WIDTH + 1);
    localparam logic [CC_W-1:0]  HALF_LOAD = CC_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CC_W-1:0]  BIT_LOAD  = CC_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] START_W   = WIDTH'(START_VALUE);
    localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] END_W     = WIDTH'(END_VALUE);
    localparam bit               HALT_ON_ERR = (STOP_ON_ERR != 0);
`ifdef SEQ_CHECK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CLKS - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BREAK, S_CHECK, S_DONE
    } state_t;

    state_t               state_r;
    logic                 sync1_r;
    logic                 sync2_r;
    logic [CC_W-1:0]      clk_cnt_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic [WIDTH-1:0]     shift_r;
    logic [WIDTH-1:0]     rx_data_r;
    logic                 rx_valid_r;
    logic [WIDTH-1:0]     expected_r;
    logic                 done_r;
    logic                 pass_r;
    logic                 fail_r;
    logic                 frame_err_r;
    logic [CNT_WIDTH-1:0] err_cnt_r;
    logic [CNT_WIDTH-1:0] frame_cnt_r;
    logic [WIDTH-1:0]     bad_data_r;
    logic                 bad_seen_r;
    logic                 rx_s;
    logic                 mismatch_s;
    logic                 at_end_s;
`ifdef SEQ_CHECK_TIMEOUT_EN
    logic [WD_W-1:0]      wd_cnt_r;
    logic                 timeout_r;
`endif

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1'b1);
    endfunction

    assign rx_s       = sync2_r;
    assign mismatch_s = (shift_r != expected_r);
    assign at_end_s   = (expected_r == END_W);

    // Two-flop synchroniser; resets to the idle-high line level so reset never fakes a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= mon.rx_line;
            sync2_r <= sync1_r;
        end
    end

    // Receive/check FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            clk_cnt_r   <= '0;
            bit_idx_r   <= '0;
            shift_r     <= '0;
            rx_data_r   <= '0;
            rx_valid_r  <= 1'b0;
            expected_r  <= START_W;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_r      <= 1'b0;
            frame_err_r <= 1'b0;
            err_cnt_r   <= '0;
            frame_cnt_r <= '0;
            bad_data_r  <= '0;
            bad_seen_r  <= 1'b0;
`ifdef SEQ_CHECK_TIMEOUT_EN
            wd_cnt_r    <= '0;
            timeout_r   <= 1'b0;
`endif
        end else begin
            rx_valid_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (mon.enable && !rx_s) begin
                        state_r   <= S_START;
                        clk_cnt_r <= HALF_LOAD;
`ifdef SEQ_CHECK_TIMEOUT_EN
                        wd_cnt_r  <= '0;
                    end else if (mon.enable && (wd_cnt_r == WD_LAST)) begin
                        timeout_r <= 1'b1;
                        fail_r    <= 1'b1;
                        done_r    <= 1'b1;
                        pass_r    <= 1'b0;
                        state_r   <= S_DONE;
                    end else if (mon.enable) begin
                        wd_cnt_r  <= wd_cnt_r + WD_W'(1'b1);
`endif
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_START: begin
                    if (clk_cnt_r == '0) begin
                        // A start bit that has gone high again by mid-bit is a glitch, not a frame.
                        if (!rx_s) begin
                            state_r   <= S_DATA;
                            clk_cnt_r <= BIT_LOAD;
                            bit_idx_r <= '0;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r - CC_W'(1'b1);
                    end
                end
                S_DATA: begin
                    if (clk_cnt_r == '0) begin
                        shift_r   <= {rx_s, shift_r[WIDTH-1:1]};
                        clk_cnt_r <= BIT_LOAD;
                        if (bit_idx_r == LAST_IDX) begin
                            state_r <= S_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_W'(1'b1);
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r - CC_W'(1'b1);
                    end
                end
                S_STOP: begin
                    if (clk_cnt_r == '0) begin
                        if (rx_s) begin
                            state_r <= S_CHECK;
                        end else begin
                            frame_err_r <= 1'b1;
                            fail_r      <= 1'b1;
                            err_cnt_r   <= sat_inc(err_cnt_r);
                            state_r     <= S_BREAK;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r - CC_W'(1'b1);
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_BREAK;
                    end
                end
                S_CHECK: begin
                    rx_data_r   <= shift_r;
                    rx_valid_r  <= 1'b1;
                    frame_cnt_r <= sat_inc(frame_cnt_r);
                    if (mismatch_s) begin
                        err_cnt_r <= sat_inc(err_cnt_r);
                        fail_r    <= 1'b1;
                        if (!bad_seen_r) begin
                            bad_data_r <= shift_r;
                            bad_seen_r <= 1'b1;
                        end
                    end
                    if ((!mismatch_s || !HALT_ON_ERR) && at_end_s) begin
                        done_r  <= 1'b1;
                        pass_r  <= !(fail_r || mismatch_s);
                        state_r <= S_DONE;
                    end else if (mismatch_s && HALT_ON_ERR) begin
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        expected_r <= expected_r + STEP_W;
                        state_r    <= S_IDLE;
                    end
                end
                S_DONE: begin
                    state_r <= S_DONE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign mon.rx_data   = rx_data_r;
    assign mon.rx_valid  = rx_valid_r;
    assign mon.expected  = expected_r;
    assign mon.done      = done_r;
    assign mon.pass      = pass_r;
    assign mon.fail      = fail_r;
    assign mon.frame_err = frame_err_r;
    assign mon.err_cnt   = err_cnt_r;
    assign mon.frame_cnt = frame_cnt_r;
    assign mon.bad_data  = bad_data_r;
`ifdef SEQ_CHECK_TIMEOUT_EN
    assign mon.timeout   = timeout_r;
`endif
endmodule

// File: tb/tb_uart_seq_checker.sv
// Bench for uart_seq_checker: a default 8-bit checker driven from a vector table and a full 1..255 run,
// plus a 4-bit step-3 continue-on-error checker driven randomly against a frame-level reference model.
module tb_uart_seq_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    int total = 0;
    int bad = 0;
    int vcnt_a = 0;
    int vcnt_b = 0;

    uart_seq_checker_if #(.WIDTH(8), .CNT_WIDTH(8)) if_a ();
    uart_seq_checker_if #(.WIDTH(4), .CNT_WIDTH(8)) if_b ();

    uart_seq_checker #(
        .WIDTH(8), .CLKS_PER_BIT(2), .START_VALUE(1), .STEP(1), .END_VALUE(255),
        .STOP_ON_ERR(1), .CNT_WIDTH(8)
`ifdef SEQ_CHECK_TIMEOUT_EN
        , .TIMEOUT_CLKS(60000)
`endif
    ) dut_a (.clk(clk), .rst_n(rst_a_n), .mon(if_a));

    uart_seq_checker #(
        .WIDTH(4), .CLKS_PER_BIT(8), .START_VALUE(0), .STEP(3), .END_VALUE(15),
        .STOP_ON_ERR(0), .CNT_WIDTH(8)
`ifdef SEQ_CHECK_TIMEOUT_EN
        , .TIMEOUT_CLKS(60000)
`endif
    ) dut_b (.clk(clk), .rst_n(rst_b_n), .mon(if_b));

`ifdef SEQ_CHECK_TIMEOUT_EN
    logic rst_c_n = 1'b0;
    uart_seq_checker_if #(.WIDTH(8), .CNT_WIDTH(8)) if_c ();
    uart_seq_checker #(
        .WIDTH(8), .CLKS_PER_BIT(2), .START_VALUE(1), .STEP(1), .END_VALUE(255),
        .STOP_ON_ERR(1), .CNT_WIDTH(8), .TIMEOUT_CLKS(100)
    ) dut_c (.clk(clk), .rst_n(rst_c_n), .mon(if_c));
`endif

    always @(negedge clk) begin
        if (if_a.rx_valid === 1'b1) vcnt_a <= vcnt_a + 1;
        if (if_b.rx_valid === 1'b1) vcnt_b <= vcnt_b + 1;
    end

    typedef struct {
        bit         rst_before;
        logic [7:0] word;
        bit         stop_ok;
        int         e_expected, e_err, e_fc, e_fail, e_done, e_fe, e_bad, e_rxd, e_valid;
    } vec_t;
    vec_t vecs [6];

    // Frame-level reference model of the 4-bit checker (START 0, STEP 3, END 15, keep going on errors).
    int m_exp, m_err, m_fc, m_fail, m_done, m_pass, m_fe, m_bad, m_bad_seen, m_rxd, m_valid, base_b;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) if_a.rx_line = v;
        else          if_b.rx_line = v;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] w, input logic stop_ok);
        int cpb;
        int wd;
        cpb = (sel == 0) ? 2 : 8;
        wd  = (sel == 0) ? 8 : 4;
        set_line(sel, 1'b0);
        tick(cpb);
        for (int i = 0; i < wd; i++) begin
            set_line(sel, w[i]);
            tick(cpb);
        end
        set_line(sel, stop_ok);
        tick(cpb);
        set_line(sel, 1'b1);
        tick(3 * cpb + 4);
    endtask

    task automatic reset_dut(input int sel);
        if (sel == 0) rst_a_n = 1'b0; else rst_b_n = 1'b0;
        tick(3);
        if (sel == 0) rst_a_n = 1'b1; else rst_b_n = 1'b1;
        tick(2);
    endtask

    task automatic model_reset();
        reset_dut(1);
        m_exp = 0; m_err = 0; m_fc = 0; m_fail = 0; m_done = 0; m_pass = 0;
        m_fe = 0; m_bad = 0; m_bad_seen = 0; m_rxd = 0; m_valid = 0;
        base_b = vcnt_b;
    endtask

    task automatic run_b(input int w, input bit stop_ok, input string tag);
        if (m_done == 0) begin
            if (!stop_ok) begin
                m_fe = 1; m_fail = 1; m_err = (m_err < 255) ? m_err + 1 : 255;
            end else begin
                m_fc = (m_fc < 255) ? m_fc + 1 : 255;
                m_rxd = w;
                m_valid = m_valid + 1;
                if (w != m_exp) begin
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                    m_fail = 1;
                    if (m_bad_seen == 0) begin m_bad = w; m_bad_seen = 1; end
                end
                if (m_exp == 15) begin
                    m_done = 1; m_pass = (m_fail == 0) ? 1 : 0;
                end else begin
                    m_exp = (m_exp + 3) % 16;
                end
            end
        end
        send_frame(1, 8'(w), stop_ok);
        chk({tag, " expected"},  32'(if_b.expected),  32'(m_exp));
        chk({tag, " err_cnt"},   32'(if_b.err_cnt),   32'(m_err));
        chk({tag, " frame_cnt"}, 32'(if_b.frame_cnt), 32'(m_fc));
        chk({tag, " fail"},      32'(if_b.fail),      32'(m_fail));
        chk({tag, " done"},      32'(if_b.done),      32'(m_done));
        chk({tag, " pass"},      32'(if_b.pass),      32'(m_pass));
        chk({tag, " frame_err"}, 32'(if_b.frame_err), 32'(m_fe));
        chk({tag, " rx_data"},   32'(if_b.rx_data),   32'(m_rxd));
        chk({tag, " bad_data"},  32'(if_b.bad_data),  32'(m_bad));
        chk({tag, " pulses"},    32'(vcnt_b - base_b), 32'(m_valid));
    endtask

    initial begin
        int base;
        if_a.rx_line = 1'b1; if_a.enable = 1'b0;
        if_b.rx_line = 1'b1; if_b.enable = 1'b0;
`ifdef SEQ_CHECK_TIMEOUT_EN
        if_c.rx_line = 1'b1; if_c.enable = 1'b1;
`endif
        //            rst word  stop  exp err fc fail done fe bad rxd valid
        vecs[0] = '{1'b1, 8'd1, 1'b0, 1, 1, 0, 1, 0, 1, 0, 0, 0};
        vecs[1] = '{1'b0, 8'd1, 1'b1, 2, 1, 1, 1, 0, 1, 0, 1, 1};
        vecs[2] = '{1'b1, 8'd1, 1'b1, 2, 0, 1, 0, 0, 0, 0, 1, 1};
        vecs[3] = '{1'b0, 8'd2, 1'b1, 3, 0, 2, 0, 0, 0, 0, 2, 1};
        vecs[4] = '{1'b0, 8'd7, 1'b1, 3, 1, 3, 1, 1, 0, 7, 7, 1};
        vecs[5] = '{1'b0, 8'd3, 1'b1, 3, 1, 3, 1, 1, 0, 7, 7, 0};

        tick(4);
        reset_dut(0);
        chk("rst expected",  32'(if_a.expected),  32'd1);
        chk("rst rx_data",   32'(if_a.rx_data),   32'd0);
        chk("rst rx_valid",  32'(if_a.rx_valid),  32'd0);
        chk("rst done",      32'(if_a.done),      32'd0);
        chk("rst pass",      32'(if_a.pass),      32'd0);
        chk("rst fail",      32'(if_a.fail),      32'd0);
        chk("rst frame_err", 32'(if_a.frame_err), 32'd0);
        chk("rst err_cnt",   32'(if_a.err_cnt),   32'd0);
        chk("rst frame_cnt", 32'(if_a.frame_cnt), 32'd0);
        chk("rst bad_data",  32'(if_a.bad_data),  32'd0);

        if_a.enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].rst_before) reset_dut(0);
            base = vcnt_a;
            send_frame(0, vecs[i].word, vecs[i].stop_ok);
            chk($sformatf("vec%0d expected", i),  32'(if_a.expected),  32'(vecs[i].e_expected));
            chk($sformatf("vec%0d err_cnt", i),   32'(if_a.err_cnt),   32'(vecs[i].e_err));
            chk($sformatf("vec%0d frame_cnt", i), 32'(if_a.frame_cnt), 32'(vecs[i].e_fc));
            chk($sformatf("vec%0d fail", i),      32'(if_a.fail),      32'(vecs[i].e_fail));
            chk($sformatf("vec%0d done", i),      32'(if_a.done),      32'(vecs[i].e_done));
            chk($sformatf("vec%0d pass", i),      32'(if_a.pass),      32'd0);
            chk($sformatf("vec%0d frame_err", i), 32'(if_a.frame_err), 32'(vecs[i].e_fe));
            chk($sformatf("vec%0d bad_data", i),  32'(if_a.bad_data),  32'(vecs[i].e_bad));
            chk($sformatf("vec%0d rx_data", i),   32'(if_a.rx_data),   32'(vecs[i].e_rxd));
            chk($sformatf("vec%0d pulses", i),    32'(vcnt_a - base),  32'(vecs[i].e_valid));
        end

        // Full clean run 1..255.
        reset_dut(0);
        base = vcnt_a;
        for (int w = 1; w <= 255; w++) send_frame(0, 8'(w), 1'b1);
        chk("full done",      32'(if_a.done),      32'd1);
        chk("full pass",      32'(if_a.pass),      32'd1);
        chk("full fail",      32'(if_a.fail),      32'd0);
        chk("full frame_cnt", 32'(if_a.frame_cnt), 32'd255);
        chk("full err_cnt",   32'(if_a.err_cnt),   32'd0);
        chk("full expected",  32'(if_a.expected),  32'd255);
        chk("full pulses",    32'(vcnt_a - base),  32'd255);
        if_a.enable = 1'b0;

        // 4-bit checker: reset value, glitch rejection, enable gating.
        model_reset();
        chk("b rst expected", 32'(if_b.expected), 32'd0);
        if_b.enable = 1'b1;
        set_line(1, 1'b0); tick(1); set_line(1, 1'b1); tick(40);
        chk("glitch frame_cnt", 32'(if_b.frame_cnt), 32'd0);
        chk("glitch err_cnt",   32'(if_b.err_cnt),   32'd0);
        chk("glitch frame_err", 32'(if_b.frame_err), 32'd0);
        chk("glitch pulses",    32'(vcnt_b - base_b), 32'd0);
        if_b.enable = 1'b0;
        send_frame(1, 8'd0, 1'b1);
        chk("disabled frame_cnt", 32'(if_b.frame_cnt), 32'd0);
        chk("disabled expected",  32'(if_b.expected),  32'd0);
        if_b.enable = 1'b1;

        // One corrupt word among 0,3,..,15.
        run_b(0, 1'b1, "seq0");
        run_b(3, 1'b1, "seq1");
        run_b(5, 1'b1, "seq2");
        run_b(9, 1'b1, "seq3");
        run_b(12, 1'b1, "seq4");
        run_b(15, 1'b1, "seq5");
        chk("seq final pass", 32'(if_b.pass),    32'd0);
        chk("seq final err",  32'(if_b.err_cnt), 32'd1);

        // Random words and stop bits against the model.
        for (int t = 0; t < 5; t++) begin
            model_reset();
            for (int f = 0; f < 40 && m_done == 0; f++) begin
                int w;
                bit ok;
                w  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : m_exp;
                ok = ($urandom_range(0, 7) != 0);
                run_b(w, ok, $sformatf("rnd%0d.%0d", t, f));
            end
            run_b(int'($urandom_range(0, 15)), 1'b1, $sformatf("rnd%0d.post", t));
        end

        // Reset in the middle of a frame.
        model_reset();
        run_b(0, 1'b1, "pre");
        set_line(1, 1'b0); tick(8);
        set_line(1, 1'b1); tick(8);
        set_line(1, 1'b0); tick(4);
        rst_b_n = 1'b0; tick(2);
        set_line(1, 1'b1); tick(2);
        rst_b_n = 1'b1; tick(2);
        chk("midrst expected",  32'(if_b.expected),  32'd0);
        chk("midrst frame_cnt", 32'(if_b.frame_cnt), 32'd0);
        chk("midrst rx_data",   32'(if_b.rx_data),   32'd0);
        chk("midrst done",      32'(if_b.done),      32'd0);
        chk("midrst fail",      32'(if_b.fail),      32'd0);
        base = vcnt_b;
        send_frame(1, 8'd0, 1'b1);
        chk("midrst after expected",  32'(if_b.expected),  32'd3);
        chk("midrst after frame_cnt", 32'(if_b.frame_cnt), 32'd1);
        chk("midrst after pulses",    32'(vcnt_b - base),  32'd1);

`ifdef SEQ_CHECK_TIMEOUT_EN
        rst_c_n = 1'b1;
        tick(90);
        chk("timeout early", 32'(if_c.timeout), 32'd0);
        chk("timeout early done", 32'(if_c.done), 32'd0);
        tick(20);
        chk("timeout flag", 32'(if_c.timeout), 32'd1);
        chk("timeout fail", 32'(if_c.fail),    32'd1);
        chk("timeout done", 32'(if_c.done),    32'd1);
        chk("timeout pass", 32'(if_c.pass),    32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
